// File: rtl/p1_pkg.sv
// Shared types and default constants for the p1 serial pattern transmitter.
package p1_pkg;

    typedef enum logic [1:0] {
        P1_TX_IDLE  = 2'd0,
        P1_TX_SHIFT = 2'd1,
        P1_TX_PAR   = 2'd2,
        P1_TX_GAP   = 2'd3
    } p1_tx_state_e;

    localparam int P1_DATA_W  = 16;
    localparam int P1_GAP_CYC = 2;

endpackage

// File: rtl/p1_pattern_tx_if.sv
// Valid/ready word input of the p1 pattern transmitter.
interface p1_pattern_tx_if #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = $clog2(DATA_W + 1)
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [LEN_W-1:0]  in_len;

    modport master (output in_valid, output in_data, output in_len, input  in_ready);
    modport slave  (input  in_valid, input  in_data, input  in_len, output in_ready);
endinterface

// File: rtl/p1_tx_shifter.sv
// Left-shift register with a remaining-bit down-counter; the load window
// left-aligns bits [len-1:0] so the MSB of the window comes out first.
module p1_tx_shifter #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] load_data,
    input  logic [LEN_W-1:0]  load_len,
    output logic              load_msb,
    output logic              msb,
    output logic              last,
    output logic              empty
);
    logic [DATA_W-1:0] aligned;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;

    // load_len is already clamped to 1..DATA_W by the caller
    assign aligned  = load_data << (LEN_W'(DATA_W) - load_len);
    assign load_msb = aligned[DATA_W-1];
    assign msb      = sh_q[DATA_W-1];
    assign last     = (cnt_q == LEN_W'(1));
    assign empty    = (cnt_q == '0);

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (load) begin
            sh_d  = aligned << 1;
            cnt_d = load_len - LEN_W'(1);
        end else if (shift) begin
            sh_d  = sh_q << 1;
            cnt_d = cnt_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/p1_pattern_tx.sv
// p1 serial pattern transmitter: words in over valid/ready, MSB-first bits out on X.
// Define P1_TX_PARITY_EN to append one even-parity bit after the data bits.
//
// state | meaning
// IDLE  | ready for a word, X at idle level
// SHIFT | data bits on X
// PAR   | even-parity bit on X (parity build only)
// GAP   | idle level for GAP_CYC cycles before the next word
module p1_pattern_tx
    import p1_pkg::*;
#(
    parameter int   DATA_W   = P1_DATA_W,
    parameter int   LEN_W    = $clog2(DATA_W + 1),
    parameter int   GAP_CYC  = P1_GAP_CYC,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    p1_pattern_tx_if.slave  in_if,
    output logic            X,
    output logic            tx_active,
    output logic            done
);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
`ifdef P1_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    p1_tx_state_e     state_q, state_d;
    logic             x_q, x_d;
    logic             act_q, act_d;
    logic             done_q, done_d;
    logic [GAP_W-1:0] gap_q, gap_d;
`ifdef P1_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             accept, load, shift;
    logic             load_msb, sh_msb, sh_last, sh_empty;
    logic [LEN_W-1:0] eff_len;

    // Ready drops combinationally with reset so nothing is accepted while held in reset
    assign in_if.in_ready = rst_n && (state_q == P1_TX_IDLE);
    assign accept         = in_if.in_valid && in_if.in_ready;
    assign eff_len        = ((in_if.in_len == '0) || (in_if.in_len > LEN_W'(DATA_W)))
                            ? LEN_W'(DATA_W) : in_if.in_len;

    p1_tx_shifter #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .shift     (shift),
        .load_data (in_if.in_data),
        .load_len  (eff_len),
        .load_msb  (load_msb),
        .msb       (sh_msb),
        .last      (sh_last),
        .empty     (sh_empty)
    );

    always_comb begin
        state_d = state_q;
        x_d     = IDLE_BIT;
        act_d   = 1'b0;
        done_d  = 1'b0;
        gap_d   = gap_q;
        load    = 1'b0;
        shift   = 1'b0;
`ifdef P1_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            P1_TX_IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    x_d     = load_msb;
                    act_d   = 1'b1;
                    done_d  = (eff_len == LEN_W'(1)) && !PAR_EN;
                    state_d = P1_TX_SHIFT;
`ifdef P1_TX_PARITY_EN
                    par_d   = load_msb;
`endif
                end
            end
            P1_TX_SHIFT: begin
                if (!sh_empty) begin
                    shift  = 1'b1;
                    x_d    = sh_msb;
                    act_d  = 1'b1;
                    done_d = sh_last && !PAR_EN;
`ifdef P1_TX_PARITY_EN
                    par_d  = par_q ^ sh_msb;
`endif
                end else begin
`ifdef P1_TX_PARITY_EN
                    x_d     = par_q;
                    act_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = P1_TX_PAR;
`else
                    if (GAP_CYC == 0) begin
                        state_d = P1_TX_IDLE;
                    end else begin
                        state_d = P1_TX_GAP;
                        gap_d   = GAP_W'(GAP_CYC - 1);
                    end
`endif
                end
            end
`ifdef P1_TX_PARITY_EN
            P1_TX_PAR: begin
                if (GAP_CYC == 0) begin
                    state_d = P1_TX_IDLE;
                end else begin
                    state_d = P1_TX_GAP;
                    gap_d   = GAP_W'(GAP_CYC - 1);
                end
            end
`endif
            P1_TX_GAP: begin
                if (gap_q == '0) begin
                    state_d = P1_TX_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = P1_TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= P1_TX_IDLE;
            x_q     <= IDLE_BIT;
            act_q   <= 1'b0;
            done_q  <= 1'b0;
            gap_q   <= '0;
`ifdef P1_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            act_q   <= act_d;
            done_q  <= done_d;
            gap_q   <= gap_d;
`ifdef P1_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign X         = x_q;
    assign tx_active = act_q;
    assign done      = done_q;
endmodule
